mem_axi_bridge: RTL and testbench
=================================

MEM_AXI_BRIDGE -- requirements
Module: mem_axi_bridge

Interface
REQ-001 Parameter ADDR_W, default 32, address width of core request and AXI address channels.
REQ-002 Parameter DATA_W, default 32, data width; legal values 32 or 64; strobe width is DATA_W/8.
REQ-003 Parameter TIMEOUT, default 0, cycles allowed per transaction before fault; 0 disables the timeout.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rstn  in  1  reset, asynchronous and active-low.
REQ-006 req_valid/req_ready  in/out  1/1  core request handshake.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  ADDR_W  byte address.
REQ-009 req_wdata/req_wstrb  in  DATA_W / DATA_W/8  store data and byte enables.
REQ-010 req_is_instr  in  1  instruction fetch tag.
REQ-011 resp_valid  out  1  one-cycle response pulse; no backpressure.
REQ-012 resp_rdata  out  DATA_W  load data, valid with resp_valid.
REQ-013 resp_err/resp_exc  out  1/3  error flag and code, valid with resp_valid.
REQ-014 bus_fault  out  1  sticky timeout indication.
REQ-015 m_is_instr  out  1  registered req_is_instr of the in-flight transaction.
REQ-016 AXI4-Lite master: m_axi_araddr/arvalid/arready, rdata/rresp/rvalid/rready, awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready; widths ADDR_W, DATA_W, DATA_W/8, 2 for resp.

Function
REQ-017 States: IDLE, RD_A, RD_D, WR_AW, WR_B, FAULT; exactly one transaction outstanding.
REQ-018 req_ready = 1 only in IDLE; request accepted when req_valid && req_ready; address, data, strobe, we, is_instr registered on acceptance.
REQ-019 Accepted load: IDLE -> RD_A with arvalid = 1 in the next cycle; arvalid held with araddr stable until arready.
REQ-020 RD_A -> RD_D on ar handshake; rready = 1 only in RD_D; on rvalid: resp_valid pulses next cycle with captured rdata, state -> IDLE.
REQ-021 Accepted store: IDLE -> WR_AW, awvalid and wvalid both asserted next cycle; aw_done and w_done flags track each handshake independently; each valid drops after its own handshake.
REQ-022 Handshakes on AW and W in the same cycle, or in either order, SHALL both be accepted; WR_AW -> WR_B when both flags are set.
REQ-023 bready = 1 only in WR_B; on bvalid: resp_valid pulses next cycle with resp_rdata = 0, state -> IDLE.
REQ-024 Latency with zero-wait slave: load and store both accept-to-resp_valid = 4 cycles; next request accepted the cycle resp_valid is high.
REQ-025 Error mapping: rresp[1] = 1 gives resp_err = 1, resp_exc = 3'd1 (load) or 3'd4 (fetch, req_is_instr = 1); bresp[1] = 1 gives resp_err = 1, resp_exc = 3'd2; OKAY/EXOKAY give resp_err = 0, resp_exc = 0.
REQ-026 resp_rdata, resp_err and resp_exc hold their last values between pulses.
REQ-027 TIMEOUT > 0: a counter clears on acceptance and increments each cycle outside IDLE; when it reaches TIMEOUT before completion:
  - resp_valid pulses with resp_err = 1, resp_exc = 3'd3;
  - all AXI valids and readies are driven to 0;
  - bus_fault is set;
  - state -> FAULT.
REQ-028 FAULT is terminal until reset; req_ready = 0; late AXI responses are ignored.
REQ-029 Counter width is clog2(TIMEOUT+1); it saturates and never wraps.
REQ-030 Unaligned addresses are forwarded unchanged; alignment checks belong upstream.

Reset
REQ-031 On rstn low, asynchronously: state = IDLE, all AXI valid/ready outputs = 0, resp_valid = 0, resp_err = 0, resp_exc = 0, resp_rdata = 0, bus_fault = 0, m_is_instr = 0, counter = 0.
REQ-032 Reset mid-transaction abandons it with no resp_valid; after release, req_ready = 1 in the first cycle.

Verification
REQ-033 Load addr 0x1000, slave returns rdata 0xDEADBEEF, OKAY, zero wait -> resp_valid 4 cycles after accept, rdata 0xDEADBEEF, resp_err 0.
REQ-034 Store with wstrb 0x3, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles, single resp_valid after bvalid.
REQ-035 Fetch (req_is_instr = 1) with rresp = 2'b10 -> resp_err 1, resp_exc 3'd4, m_is_instr 1 during the transaction.
REQ-036 TIMEOUT = 8, slave never asserts arready -> resp_valid with resp_exc 3'd3 at count 8, bus_fault 1, req_ready 0 thereafter.
REQ-037 rstn pulled low while in WR_B -> bready 0 immediately, no resp_valid; next store completes normally.
REQ-038 DATA_W = 64 build, back-to-back loads -> second accept coincides with first resp_valid; 64-bit data returned intact.

Source files
------------

// File: rtl/mem_axi_bridge.sv
// Core load/store/fetch request port to AXI4-Lite master bridge.
// One transaction in flight; optional per-transaction timeout latches a terminal fault.
module mem_axi_bridge #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_wstrb,
   input  logic                  req_is_instr,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err,
   output logic [2:0]            resp_exc,
   output logic                  bus_fault,
   output logic                  m_is_instr,
   output logic [ADDR_W-1:0]     m_axi_araddr,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_W-1:0]     m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic [ADDR_W-1:0]     m_axi_awaddr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_W-1:0]     m_axi_wdata,
   output logic [DATA_W/8-1:0]   m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, FAULT} state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic                aw_done, aw_done_d, w_done, w_done_d;
   logic                req_ready_d, resp_valid_d, resp_err_d, bus_fault_d, m_is_instr_d;
   logic [DATA_W-1:0]   resp_rdata_d, wdata_d;
   logic [2:0]          resp_exc_d;
   logic [ADDR_W-1:0]   araddr_d, awaddr_d;
   logic [STRB_W-1:0]   wstrb_d;
   logic                arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d;
   logic                aw_hs, w_hs, rd_err, wr_err;

   // SLVERR and DECERR both map to an error response
   assign rd_err = (m_axi_rresp == 2'b10) || (m_axi_rresp == 2'b11);
   assign wr_err = (m_axi_bresp == 2'b10) || (m_axi_bresp == 2'b11);
   assign aw_hs  = m_axi_awvalid && m_axi_awready;
   assign w_hs   = m_axi_wvalid && m_axi_wready;

   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      aw_done_d    = aw_done;
      w_done_d     = w_done;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata;
      resp_err_d   = resp_err;
      resp_exc_d   = resp_exc;
      bus_fault_d  = bus_fault;
      m_is_instr_d = m_is_instr;
      araddr_d     = m_axi_araddr;
      awaddr_d     = m_axi_awaddr;
      wdata_d      = m_axi_wdata;
      wstrb_d      = m_axi_wstrb;
      arvalid_d    = m_axi_arvalid;
      rready_d     = m_axi_rready;
      awvalid_d    = m_axi_awvalid;
      wvalid_d     = m_axi_wvalid;
      bready_d     = m_axi_bready;

      if (state != IDLE && cnt != CNT_W'(TIMEOUT)) cnt_d = cnt + CNT_W'(1);

      unique case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               cnt_d        = '0;
               m_is_instr_d = req_is_instr;
               if (req_we) begin
                  state_d   = WR_AW;
                  awaddr_d  = req_addr;
                  wdata_d   = req_wdata;
                  wstrb_d   = req_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = RD_A;
                  araddr_d  = req_addr;
                  arvalid_d = 1'b1;
               end
            end
         end
         RD_A: begin
            if (m_axi_arvalid && m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_D;
            end
         end
         RD_D: begin
            if (m_axi_rvalid && m_axi_rready) begin
               rready_d     = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = m_axi_rdata;
               resp_err_d   = rd_err;
               resp_exc_d   = rd_err ? (m_is_instr ? 3'd4 : 3'd1) : 3'd0;
               state_d      = IDLE;
            end
         end
         WR_AW: begin
            // AW and W complete independently, in any order
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               bready_d = 1'b1;
               state_d  = WR_B;
            end
         end
         WR_B: begin
            if (m_axi_bvalid && m_axi_bready) begin
               bready_d     = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = '0;
               resp_err_d   = wr_err;
               resp_exc_d   = wr_err ? 3'd2 : 3'd0;
               state_d      = IDLE;
            end
         end
         FAULT: ;
         default: state_d = IDLE;
      endcase

      // timeout fires on the edge where the count reaches TIMEOUT; completion on that edge wins
      if (TIMEOUT != 0 && state != IDLE && state != FAULT && state_d != IDLE &&
          cnt == CNT_W'(TIMEOUT - 1)) begin
         state_d      = FAULT;
         resp_valid_d = 1'b1;
         resp_err_d   = 1'b1;
         resp_exc_d   = 3'd3;
         bus_fault_d  = 1'b1;
         arvalid_d    = 1'b0;
         rready_d     = 1'b0;
         awvalid_d    = 1'b0;
         wvalid_d     = 1'b0;
         bready_d     = 1'b0;
      end

      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         cnt           <= '0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_rdata    <= '0;
         resp_err      <= 1'b0;
         resp_exc      <= 3'd0;
         bus_fault     <= 1'b0;
         m_is_instr    <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_awaddr  <= '0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         aw_done       <= aw_done_d;
         w_done        <= w_done_d;
         req_ready     <= req_ready_d;
         resp_valid    <= resp_valid_d;
         resp_rdata    <= resp_rdata_d;
         resp_err      <= resp_err_d;
         resp_exc      <= resp_exc_d;
         bus_fault     <= bus_fault_d;
         m_is_instr    <= m_is_instr_d;
         m_axi_araddr  <= araddr_d;
         m_axi_awaddr  <= awaddr_d;
         m_axi_wdata   <= wdata_d;
         m_axi_wstrb   <= wstrb_d;
         m_axi_arvalid <= arvalid_d;
         m_axi_rready  <= rready_d;
         m_axi_awvalid <= awvalid_d;
         m_axi_wvalid  <= wvalid_d;
         m_axi_bready  <= bready_d;
      end
   end

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge: a 32-bit/TIMEOUT=8 instance with a
// configurable AXI-Lite slave, plus a 64-bit instance for back-to-back loads.
module tb_mem_axi_bridge;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   // 32-bit instance
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_is_instr = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic        resp_valid, resp_err, bus_fault, m_is_instr;
   logic [31:0] resp_rdata;
   logic [2:0]  resp_exc;
   logic [31:0] m_axi_araddr, m_axi_awaddr, m_axi_wdata;
   logic [31:0] m_axi_rdata = '0;
   logic [3:0]  m_axi_wstrb;
   logic [1:0]  m_axi_rresp = '0, m_axi_bresp = '0;
   logic        m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready;
   logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0, m_axi_awready = 1'b0;
   logic        m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;

   // 64-bit instance
   logic        req_valid64 = 1'b0, req_ready64;
   logic [31:0] req_addr64 = '0;
   logic [63:0] req_wdata64 = '0;
   logic [7:0]  req_wstrb64 = '0;
   logic        resp_valid64, resp_err64, bus_fault64, m_is_instr64;
   logic [63:0] resp_rdata64, wdata64;
   logic [2:0]  resp_exc64;
   logic [31:0] araddr64, awaddr64;
   logic [7:0]  wstrb64;
   logic [63:0] rdata64 = '0;
   logic [1:0]  rresp64 = '0;
   logic        arvalid64, rready64, awvalid64, wvalid64, bready64;
   logic        arready64 = 1'b0, rvalid64 = 1'b0;

   // slave controls for the 32-bit instance
   int          ar_delay = 0, aw_delay = 0, w_delay = 0;
   int          ar_wait = 0, aw_wait = 0, w_wait = 0;
   bit          ar_block = 0, b_hold = 0, inject_late = 0;
   bit          ar_seen = 0, r_seen = 0, aw_seen = 0, w_seen = 0, b_seen = 0;
   bit          aw_got = 0, w_got = 0;
   logic [31:0] rd_data = '0;
   logic [1:0]  rd_resp = '0, wr_resp = '0;
   bit          ar_seen64 = 0, r_seen64 = 0;
   logic [31:0] ar_addr_seen64 = '0;

   int          aw_cyc, w_cyc, instr_low;

   always #5 clk = ~clk;

   mem_axi_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_is_instr(req_is_instr),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .resp_exc(resp_exc),
      .bus_fault(bus_fault), .m_is_instr(m_is_instr),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready), .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
   );

   mem_axi_bridge #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(0)) dut64 (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid64), .req_ready(req_ready64), .req_we(1'b0), .req_addr(req_addr64),
      .req_wdata(req_wdata64), .req_wstrb(req_wstrb64), .req_is_instr(1'b0),
      .resp_valid(resp_valid64), .resp_rdata(resp_rdata64), .resp_err(resp_err64),
      .resp_exc(resp_exc64), .bus_fault(bus_fault64), .m_is_instr(m_is_instr64),
      .m_axi_araddr(araddr64), .m_axi_arvalid(arvalid64), .m_axi_arready(arready64),
      .m_axi_rdata(rdata64), .m_axi_rresp(rresp64), .m_axi_rvalid(rvalid64),
      .m_axi_rready(rready64), .m_axi_awaddr(awaddr64), .m_axi_awvalid(awvalid64),
      .m_axi_awready(1'b0), .m_axi_wdata(wdata64), .m_axi_wstrb(wstrb64),
      .m_axi_wvalid(wvalid64), .m_axi_wready(1'b0), .m_axi_bresp(2'b00),
      .m_axi_bvalid(1'b0), .m_axi_bready(bready64)
   );

   // Slave for the 32-bit instance: handshakes of the last rising edge are
   // detected from values seen at the previous falling edge, then readies are redriven.
   always @(negedge clk) begin
      if (!rstn) begin
         m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
         m_axi_bvalid = 0; ar_seen = 0; r_seen = 0; aw_seen = 0; w_seen = 0; b_seen = 0;
         aw_got = 0; w_got = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
      end else begin
         if (r_seen && m_axi_rvalid) m_axi_rvalid = 0;
         if (ar_seen && m_axi_arready) begin
            m_axi_rvalid = 1; m_axi_rdata = rd_data; m_axi_rresp = rd_resp;
         end
         if (aw_seen && m_axi_awready) aw_got = 1;
         if (w_seen && m_axi_wready) w_got = 1;
         if (b_seen && m_axi_bvalid) m_axi_bvalid = 0;
         if (aw_got && w_got && !b_hold) begin
            m_axi_bvalid = 1; m_axi_bresp = wr_resp; aw_got = 0; w_got = 0;
         end
         if (inject_late) begin m_axi_rvalid = 1; m_axi_bvalid = 1; end
         if (m_axi_arvalid && !ar_block) begin ar_wait++; m_axi_arready = (ar_wait >= ar_delay); end
         else begin ar_wait = 0; m_axi_arready = 0; end
         if (m_axi_awvalid) begin aw_wait++; m_axi_awready = (aw_wait >= aw_delay); end
         else begin aw_wait = 0; m_axi_awready = 0; end
         if (m_axi_wvalid) begin w_wait++; m_axi_wready = (w_wait >= w_delay); end
         else begin w_wait = 0; m_axi_wready = 0; end
         ar_seen = m_axi_arvalid; r_seen = m_axi_rready; aw_seen = m_axi_awvalid;
         w_seen = m_axi_wvalid; b_seen = m_axi_bready;
      end
   end

   // Zero-wait read slave for the 64-bit instance; data depends on address
   always @(negedge clk) begin
      if (!rstn) begin
         arready64 = 0; rvalid64 = 0; ar_seen64 = 0; r_seen64 = 0;
      end else begin
         if (r_seen64 && rvalid64) rvalid64 = 0;
         if (ar_seen64 && arready64) begin
            rvalid64 = 1; rresp64 = 2'b00;
            rdata64 = (ar_addr_seen64 == 32'h2000) ? 64'h0123_4567_89AB_CDEF : 64'hFEDC_BA98_7654_3210;
         end
         arready64 = 1;
         ar_seen64 = arvalid64; ar_addr_seen64 = araddr64; r_seen64 = rready64;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // present a request at a falling edge and hold it until accepted (bounded)
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input logic instr);
      bit ok, rdy;
      @(negedge clk);
      req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
      req_is_instr = instr; ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         rdy = req_ready;
         @(posedge clk);
         ok = rdy;
      end
      #1 req_valid = 0;
      check("req_accept", 64'(ok), 64'd1);
   endtask

   // cyc counts the accept cycle as cycle 1; returns the cycle resp_valid is seen
   task automatic wait_resp(input int max, output int cyc);
      cyc = 2; aw_cyc = 0; w_cyc = 0; instr_low = 0;
      while (cyc <= max && resp_valid !== 1'b1) begin
         if (m_axi_awvalid) aw_cyc++;
         if (m_axi_wvalid) w_cyc++;
         if (!m_is_instr) instr_low++;
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, bad;
      bit ok, rdy;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_axi_ctl", 64'({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
      check("rst_resp", 64'({resp_valid, resp_err, resp_exc, bus_fault, m_is_instr}), 64'd0);
      check("rst_rdata", 64'(resp_rdata), 64'd0);
      @(negedge clk) rstn = 1;
      #1 check("rst_req_ready", 64'(req_ready), 64'd1);

      // zero-wait load
      rd_data = 32'hDEAD_BEEF; rd_resp = 2'b00;
      do_req(0, 32'h0000_1000, 32'h0, 4'h0, 0);
      check("ld_ar", 64'({m_axi_arvalid, m_axi_araddr}), {31'd0, 1'b1, 32'h0000_1000});
      wait_resp(20, cyc);
      check("ld_latency", 64'(cyc), 64'd4);
      check("ld_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);
      check("ld_err", 64'({resp_err, resp_exc}), 64'd0);
      check("ld_ready_at_resp", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      check("ld_pulse", 64'(resp_valid), 64'd0);
      check("ld_hold", 64'(resp_rdata), 64'hDEAD_BEEF);

      // unaligned store, AW held 3 cycles, W immediate
      aw_delay = 3; w_delay = 0; wr_resp = 2'b00;
      do_req(1, 32'h0000_2006, 32'hA5A5_1234, 4'h3, 0);
      check("st_aw", 64'(m_axi_awaddr), 64'h0000_2006);
      check("st_w", 64'({m_axi_wstrb, m_axi_wdata}), {28'd0, 4'h3, 32'hA5A5_1234});
      wait_resp(20, cyc);
      check("st_latency", 64'(cyc), 64'd6);
      check("st_aw_cycles", 64'(aw_cyc), 64'd3);
      check("st_w_cycles", 64'(w_cyc), 64'd1);
      check("st_rdata_zero", 64'(resp_rdata), 64'd0);
      check("st_err", 64'({resp_err, resp_exc}), 64'd0);
      bad = 0;
      repeat (3) begin @(posedge clk); #1; if (resp_valid) bad++; end
      check("st_single_pulse", 64'(bad), 64'd0);

      // W after AW, SLVERR on B
      aw_delay = 0; w_delay = 2; wr_resp = 2'b10;
      do_req(1, 32'h0000_2010, 32'h0000_0055, 4'hF, 0);
      wait_resp(20, cyc);
      check("stw_latency", 64'(cyc), 64'd5);
      check("stw_cycles", 64'({aw_cyc, w_cyc}), {32'd1, 32'd2});
      check("stw_err", 64'({resp_err, resp_exc}), 64'({1'b1, 3'd2}));

      // zero-wait store, EXOKAY
      w_delay = 0; wr_resp = 2'b01;
      do_req(1, 32'h0000_2020, 32'h1, 4'h1, 0);
      wait_resp(20, cyc);
      check("st0_latency", 64'(cyc), 64'd4);
      check("st0_err", 64'({resp_err, resp_exc}), 64'd0);

      // fetch with SLVERR
      rd_data = 32'h1111_2222; rd_resp = 2'b10;
      do_req(0, 32'h0000_4000, 32'h0, 4'h0, 1);
      check("fe_is_instr", 64'(m_is_instr), 64'd1);
      wait_resp(20, cyc);
      check("fe_latency", 64'(cyc), 64'd4);
      check("fe_instr_held", 64'(instr_low), 64'd0);
      check("fe_err", 64'({resp_err, resp_exc}), 64'({1'b1, 3'd4}));

      // data load with DECERR
      rd_resp = 2'b11;
      do_req(0, 32'h0000_4004, 32'h0, 4'h0, 0);
      check("le_is_instr", 64'(m_is_instr), 64'd0);
      wait_resp(20, cyc);
      check("le_err", 64'({resp_err, resp_exc}), 64'({1'b1, 3'd1}));

      // reset while in WR_B
      b_hold = 1; wr_resp = 2'b00;
      do_req(1, 32'h0000_5000, 32'h77, 4'h1, 0);
      cyc = 0;
      while (cyc < 20 && m_axi_bready !== 1'b1) begin @(posedge clk); #1; cyc++; end
      check("wrb_reached", 64'(m_axi_bready), 64'd1);
      #2 rstn = 0;
      #1;
      check("wrb_rst_bready", 64'(m_axi_bready), 64'd0);
      check("wrb_rst_resp", 64'(resp_valid), 64'd0);
      b_hold = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1;
      #1 check("wrb_req_ready", 64'(req_ready), 64'd1);
      do_req(1, 32'h0000_5004, 32'h88, 4'h1, 0);
      wait_resp(20, cyc);
      check("wrb_next_latency", 64'(cyc), 64'd4);
      check("wrb_next_err", 64'({resp_err, resp_exc}), 64'd0);

      // timeout: slave never accepts AR
      ar_block = 1; rd_resp = 2'b00;
      do_req(0, 32'h0000_3000, 32'h0, 4'h0, 0);
      wait_resp(30, cyc);
      check("to_latency", 64'(cyc), 64'd10);
      check("to_err", 64'({resp_err, resp_exc}), 64'({1'b1, 3'd3}));
      check("to_fault", 64'({bus_fault, req_ready}), 64'b10);
      check("to_axi_quiet", 64'({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
      inject_late = 1; req_valid = 1; req_we = 0; bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (resp_valid || req_ready || m_axi_arvalid || m_axi_rready) bad++;
      end
      req_valid = 0; inject_late = 0;
      check("to_terminal", 64'(bad), 64'd0);
      check("to_sticky", 64'(bus_fault), 64'd1);
      @(negedge clk) rstn = 0;
      #1 check("to_rst_clear", 64'({bus_fault, resp_err, resp_exc}), 64'd0);
      ar_block = 0;
      @(negedge clk) rstn = 1;
      #1 check("to_rst_ready", 64'(req_ready), 64'd1);
      rd_data = 32'h0BAD_F00D;
      do_req(0, 32'h0000_3004, 32'h0, 4'h0, 0);
      wait_resp(20, cyc);
      check("to_recover", 64'({cyc, resp_rdata}), {32'd4, 32'h0BAD_F00D});

      // 64-bit back-to-back loads
      @(negedge clk);
      req_valid64 = 1; req_addr64 = 32'h0000_2000; ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
         rdy = req_ready64;
         @(posedge clk);
         ok = rdy;
      end
      #1 req_addr64 = 32'h0000_3000;
      check("w64_accept", 64'(ok), 64'd1);
      cyc = 2;
      while (cyc < 12 && resp_valid64 !== 1'b1) begin @(posedge clk); #1; cyc++; end
      check("w64_latency1", 64'(cyc), 64'd4);
      check("w64_rdata1", resp_rdata64, 64'h0123_4567_89AB_CDEF);
      check("w64_ready_at_resp", 64'(req_ready64), 64'd1);
      @(posedge clk); #1;
      req_valid64 = 0;
      check("w64_second_ar", 64'({arvalid64, araddr64}), {31'd0, 1'b1, 32'h0000_3000});
      cyc = 2;
      while (cyc < 12 && resp_valid64 !== 1'b1) begin @(posedge clk); #1; cyc++; end
      check("w64_latency2", 64'(cyc), 64'd4);
      check("w64_rdata2", resp_rdata64, 64'hFEDC_BA98_7654_3210);
      check("w64_status", 64'({resp_err64, resp_exc64, bus_fault64, awvalid64, wvalid64, bready64}), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
